mem_access_stage: RTL and testbench

- MEM pipeline stage sitting between the EX/MEM pipeline register and the MEM/WB register.
- Takes address, store data and control from EX/MEM, and runs a req/ack handshake with data memory.
- Handles byte, half and word sizing, with sign or zero extension on loads.
- Stalls the front of the pipe while memory is busy and inserts bubbles into MEM/WB while stalled.
- Forwards ALU result, PC, destination register and control to MEM/WB.

---
 rtl/mem_access_stage_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and
// writeback-select values also used by the writeback stage.
package mem_access_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / data replication and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory req/ack handshake with stall and timeout.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into traps.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] WriteDataIn,
  input  logic [1:0]  MemtoRegIn,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteRegIn,
  input  logic [31:0] PCResultIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBe,
  output logic [31:0] DMemWData,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic        Stall,
  output logic        BusErr,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [1:0]  MemtoRegOut,
  output logic        RegWriteOut,
  output logic [4:0]  WriteRegOut,
  output logic [31:0] PCResultOut
);

  logic [1:0]        r_state;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [1:0]        r_offset;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err;
  logic [31:0]       r_rdata;

  logic              w_idle;
  logic              w_access;
  logic              w_timeout;
  logic              w_trap_done;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata_ext;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_access  = ValidIn & (MemReadIn | MemWriteIn);
  assign w_timeout = (r_wait == WAIT_W'(MAX_WAIT - 1));

  // Store shaping is only needed while capturing in IDLE; load extraction only
  // while waiting, so one aligner serves both via the captured fields.
  mem_lane_align u_align (
    .i_size   (w_idle ? MemSizeIn         : r_size),
    .i_offset (w_idle ? ALUResultIn[1:0]  : r_offset),
    .i_signed (w_idle ? MemSignedIn       : r_signed),
    .i_wdata  (WriteDataIn),
    .i_rdata  (DMemRData),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata_ext)
  );

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_trap;

  assign w_misalign = ((MemSizeIn == SIZE_HALF) & ALUResultIn[0]) |
                      (MemSizeIn[1] & (ALUResultIn[1:0] != 2'b00));
  assign w_trap_done = (r_state == ST_DONE) & r_trap;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      r_trap <= 1'b0;
    else if (w_idle)
      r_trap <= w_access & w_misalign;
  end
`else
  assign w_trap_done = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_offset  <= '0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_addr   <= {ALUResultIn[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_we     <= MemWriteIn;
            r_offset <= ALUResultIn[1:0];
            r_size   <= MemSizeIn;
            r_signed <= MemSignedIn;
            r_wait   <= '0;
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_state   <= ST_DONE;
              r_bus_err <= 1'b1;
            end else
`endif
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_wait <= r_wait + 1'b1;
          if (DMemAck) begin
            if (!r_we)
              r_rdata <= w_rdata_ext;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DMemReq     = (r_state == ST_REQ);
  assign DMemWe      = DMemReq & r_we;
  assign DMemAddr    = r_addr;
  assign DMemBe      = r_be;
  assign DMemWData   = r_wdata;
  assign BusErr      = r_bus_err;
  assign ReadDataOut = r_rdata;

  // Stall is forced low while reset is held, matching the registered outputs.
  assign Stall = Reset & ((w_idle & w_access) | (r_state == ST_REQ));

  assign ALUResultOut = ALUResultIn;
  assign MemtoRegOut  = MemtoRegIn;
  assign WriteRegOut  = WriteRegIn;
  assign PCResultOut  = PCResultIn;
  assign RegWriteOut  = RegWriteIn & ValidIn & ~Stall & ~w_trap_done;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset and
// trap sequences, and randomized traffic against a byte-level memory model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int MAX_WAIT = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ValidIn = 1'b0, MemReadIn = 1'b0, MemWriteIn = 1'b0, MemSignedIn = 1'b0;
  logic [1:0]  MemSizeIn = '0, MemtoRegIn = '0;
  logic [31:0] ALUResultIn = '0, WriteDataIn = '0, PCResultIn = '0;
  logic        RegWriteIn = 1'b0;
  logic [4:0]  WriteRegIn = '0;
  logic        DMemReq, DMemWe, Stall, BusErr, RegWriteOut;
  logic [31:0] DMemAddr, DMemWData, ReadDataOut, ALUResultOut, PCResultOut;
  logic [3:0]  DMemBe;
  logic [1:0]  MemtoRegOut;
  logic [4:0]  WriteRegOut;

  logic        mem_ack, stray_ack = 1'b0;
  logic [31:0] mem_rdata, stray_rdata = '0;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .MemSizeIn(MemSizeIn), .MemSignedIn(MemSignedIn),
    .ALUResultIn(ALUResultIn), .WriteDataIn(WriteDataIn), .MemtoRegIn(MemtoRegIn),
    .RegWriteIn(RegWriteIn), .WriteRegIn(WriteRegIn), .PCResultIn(PCResultIn),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
    .DMemWData(DMemWData), .DMemAck(mem_ack | stray_ack),
    .DMemRData(mem_rdata ^ stray_rdata), .Stall(Stall), .BusErr(BusErr),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut), .MemtoRegOut(MemtoRegOut),
    .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut), .PCResultOut(PCResultOut)
  );

  initial forever #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge Clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0103_0507) ^ 32'h5A3C_96E1;
  endfunction

  // ---------------- memory responder ----------------
  int          ack_after = 0;
  logic        fixed_mode = 1'b0;
  logic [31:0] fixed_rdata = '0;
  logic [31:0] bus_mem [16];

  initial begin
    int req_cnt;
    req_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) bus_mem[i] = init_word(i);
    forever begin
      @(negedge Clk);
      mem_ack = 1'b0;
      if (DMemReq) begin
        req_cnt++;
        if (ack_after != 0 && req_cnt == ack_after) begin
          mem_ack = 1'b1;
          if (fixed_mode) begin
            mem_rdata = fixed_rdata;
          end else if (DMemWe) begin
            for (int b = 0; b < 4; b++)
              if (DMemBe[b]) bus_mem[DMemAddr[5:2]][8*b +: 8] = DMemWData[8*b +: 8];
          end else begin
            mem_rdata = bus_mem[DMemAddr[5:2]];
          end
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
    if (size == SIZE_BYTE) return 4'(1 << off);
    if (size == SIZE_HALF) return (off >= 2'd2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == SIZE_BYTE) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == SIZE_HALF) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [1:0] off,
                                           input logic sgn, input logic [31:0] word);
    logic [31:0] v;
    if (size == SIZE_BYTE) begin
      v = (word >> (8 * int'(off))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == SIZE_HALF) begin
      v = (word >> (16 * (int'(off) / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // ---------------- access driver ----------------
  typedef struct {
    int          stall;
    logic        saw_req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    logic        rw;
    logic [31:0] rdata;
  } obs_t;

  task automatic do_access(input logic rd, input logic wr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rw_in, input int ack, output obs_t o);
    logic [31:0] pc;
    logic [4:0]  rd_idx;
    pc = $urandom;
    rd_idx = 5'($urandom_range(1, 31));
    ack_after = ack;
    ValidIn = 1'b1; MemReadIn = rd; MemWriteIn = wr; MemSizeIn = size; MemSignedIn = sgn;
    ALUResultIn = addr; WriteDataIn = wdata; RegWriteIn = rw_in; WriteRegIn = rd_idx;
    PCResultIn = pc; MemtoRegIn = rd ? MTR_MEM : MTR_ALU;
    #1;
    o.stall = 0; o.saw_req = 1'b0;
    o.addr = '0; o.be = '0; o.wdata = '0; o.we = 1'b0;
    while (Stall && o.stall < 40) begin
      o.stall++;
      check("rw_bubble", 64'(RegWriteOut), 64'(0));
      if (DMemReq) begin
        if (!o.saw_req) begin
          o.saw_req = 1'b1;
          o.addr = DMemAddr; o.be = DMemBe; o.wdata = DMemWData; o.we = DMemWe;
        end else begin
          check("req_hold_addr", {DMemAddr, DMemBe}, {o.addr, o.be});
          check("req_hold_data", {DMemWData, DMemWe}, {o.wdata, o.we});
        end
      end
      next_cycle();
    end
    check("stall_bounded", 64'(Stall), 64'(0));
    o.err = BusErr; o.rw = RegWriteOut; o.rdata = ReadDataOut;
    check("pass_alu", 64'(ALUResultOut), 64'(addr));
    check("pass_pc", {PCResultOut, WriteRegOut, MemtoRegOut}, {pc, rd_idx, (rd ? MTR_MEM : MTR_ALU)});
    ValidIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; RegWriteIn = 1'b0;
    next_cycle();
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, wdata, rdata;
    int          ack;
    int          exp_stall;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_read;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  obs_t o;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // name rd wr size sgn addr wdata rdata ack stall exp_addr be exp_wdata exp_read err
    vecs.push_back('{"wload",  1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 2, 3,
                     32'h0000_0104, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{"sbyte",  1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 1, 2,
                     32'h0000_0200, 4'h8, 32'h0, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{"ubyte",  1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 1, 2,
                     32'h0000_0200, 4'h8, 32'h0, 32'h0000_0080, 1'b0});
    vecs.push_back('{"hstore", 1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h0000_0012, 32'h0000_ABCD, 32'h0, 1, 2,
                     32'h0000_0010, 4'hC, 32'hABCD_ABCD, 32'h0, 1'b0});
    vecs.push_back('{"timeout", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0040, 32'h0, 32'h1111_1111, 0,
                     1 + MAX_WAIT, 32'h0000_0040, 4'hF, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{"shalf",  1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h0000_0022, 32'h0, 32'h8001_7FFF, 3, 4,
                     32'h0000_0020, 4'hC, 32'h0, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{"rw_both", 1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h0000_0031, 32'h1234_565A, 32'h0, 1, 2,
                     32'h0000_0030, 4'h2, 32'h5A5A_5A5A, 32'h0, 1'b0});
    vecs.push_back('{"rsvd_sz", 1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0008, 32'h0, 32'h8765_4321, 1, 2,
                     32'h0000_0008, 4'hF, 32'h0, 32'h8765_4321, 1'b0});
`ifndef MISALIGN_TRAP_EN
    vecs.push_back('{"wtrunc", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_5678, 1, 2,
                     32'h0000_0100, 4'hF, 32'h0, 32'h1234_5678, 1'b0});
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    // Reset state, with a pending access on the inputs.
    ValidIn = 1'b1; MemReadIn = 1'b1;
    repeat (2) next_cycle();
    check("rst_ctrl", {DMemReq, DMemWe, Stall, BusErr}, 64'h0);
    check("rst_addr_be", {DMemAddr, DMemBe}, 64'h0);
    check("rst_data", {DMemWData, ReadDataOut}, 64'h0);
    ValidIn = 1'b0; MemReadIn = 1'b0;
    Reset = 1'b1;
    next_cycle();

    // Non-memory instruction: no stall, register write passes straight through.
    ValidIn = 1'b1; RegWriteIn = 1'b1; ALUResultIn = 32'h0BAD_F00D; MemtoRegIn = MTR_ALU;
    #1;
    check("nonmem_stall", 64'(Stall), 64'(0));
    check("nonmem_rw", 64'(RegWriteOut), 64'(1));
    ValidIn = 1'b0; RegWriteIn = 1'b0;
    next_cycle();

    fixed_mode = 1'b1;
    foreach (vecs[i]) begin
      fixed_rdata = vecs[i].rdata;
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                vecs[i].wdata, ~vecs[i].wr, vecs[i].ack, o);
      check({vecs[i].name, "_stall"}, 64'(o.stall), 64'(vecs[i].exp_stall));
      check({vecs[i].name, "_req"}, {o.saw_req, o.we}, {1'b1, vecs[i].wr});
      check({vecs[i].name, "_addr_be"}, {o.addr, o.be}, {vecs[i].exp_addr, vecs[i].exp_be});
      check({vecs[i].name, "_wdata"}, 64'(o.wdata), 64'(vecs[i].exp_wdata));
      check({vecs[i].name, "_done"}, {o.err, o.rw}, {vecs[i].exp_err, ~vecs[i].wr});
      if (!vecs[i].wr) check({vecs[i].name, "_read"}, 64'(o.rdata), 64'(vecs[i].exp_read));
      check({vecs[i].name, "_err_pulse"}, 64'(BusErr), 64'(0));
    end

    // Reset in the second REQ cycle, then a stray ack, then a normal load.
    ack_after = 0;
    ValidIn = 1'b1; MemReadIn = 1'b1; MemSizeIn = SIZE_WORD; ALUResultIn = 32'h0000_0004;
    next_cycle();
    next_cycle();
    check("mid_req", {DMemReq, Stall}, {1'b1, 1'b1});
    Reset = 1'b0;
    #1;
    check("mid_rst_drop", {DMemReq, Stall}, {1'b0, 1'b0});
    ValidIn = 1'b0; MemReadIn = 1'b0;
    stray_ack = 1'b1; stray_rdata = 32'h5555_5555;
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    stray_ack = 1'b0; stray_rdata = '0;
    check("stray_ack", {Stall, DMemReq, ReadDataOut}, 64'h0);
    fixed_rdata = 32'hCAFE_F00D;
    do_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 1, o);
    check("post_rst_load", {o.rdata, 32'(o.stall)}, {32'hCAFE_F00D, 32'd2});

`ifdef MISALIGN_TRAP_EN
    do_access(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0000_0101, 32'h0, 1'b1, 1, o);
    check("trap_noreq", 64'(o.saw_req), 64'(0));
    check("trap_stall", 64'(o.stall), 64'(1));
    check("trap_done", {o.err, o.rw}, {1'b1, 1'b0});
    check("trap_pulse", 64'(BusErr), 64'(0));
`endif

    // Randomized traffic against the byte-addressed model.
    fixed_mode = 1'b0;
    for (int n = 0; n < 60; n++) begin
      int          op, word, ack;
      logic [1:0]  size, off;
      logic        sgn;
      logic [31:0] addr, wd, exp_v;
      logic [3:0]  be;
      op   = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      off  = 2'($urandom_range(0, 3));
`ifdef MISALIGN_TRAP_EN
      if (size == SIZE_HALF) off[0] = 1'b0;
      if (size[1]) off = 2'b00;
`endif
      word = $urandom_range(0, 15);
      sgn  = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_FFC0) | 32'(word * 4) | 32'(off);
      wd   = $urandom;
      ack  = $urandom_range(1, MAX_WAIT - 1);
      if (op == 0) begin
        ValidIn = 1'b1; RegWriteIn = 1'b1; ALUResultIn = addr;
        #1;
        check("rnd_nonmem", {Stall, RegWriteOut, ALUResultOut}, {1'b0, 1'b1, addr});
        ValidIn = 1'b0; RegWriteIn = 1'b0;
        next_cycle();
      end else if (op == 1) begin
        exp_v = ref_load(size, off, sgn, ref_mem[word]);
        do_access(1'b1, 1'b0, size, sgn, addr, wd, 1'b1, ack, o);
        check("rnd_load", {o.rdata, 32'(o.stall)}, {exp_v, 32'(ack + 1)});
        check("rnd_load_req", {o.addr, o.be}, {addr & 32'hFFFF_FFFC, 4'hF & ref_be(size, off)});
      end else begin
        be    = ref_be(size, off);
        exp_v = ref_wdata(size, wd);
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[word][8*b +: 8] = exp_v[8*b +: 8];
        do_access(1'b0, 1'b1, size, sgn, addr, wd, 1'b0, ack, o);
        check("rnd_store", {o.we, o.be, o.wdata}, {1'b1, be, exp_v});
        check("rnd_store_addr", {o.addr, 32'(o.stall)}, {addr & 32'hFFFF_FFFC, 32'(ack + 1)});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
